// File: rtl/synth_pkg.sv
// synth_pkg: definitions shared by the synth core's PWM transmitter and the
// pwm_demod receiver, so both sides agree on width and period.
//   SYNTH_WIDTH    - default sample width used by the synth core
//   demod_state_t  - receiver FSM states (ACQ: searching, RUN: tracking edges)
//   pwm_period()   - PWM period in clocks for a given sample width (2**width)
package synth_pkg;

  localparam int SYNTH_WIDTH = 8;

  typedef enum logic {
    ACQ = 1'b0,
    RUN = 1'b1
  } demod_state_t;

  function automatic int pwm_period(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// pwm_sync: brings the asynchronous PWM input into the clk domain and flags
// rising edges.
//   clk    - clock, rising edge
//   rstn   - synchronous active-low reset, clears all three flops
//   pwm_in - asynchronous PWM stream
//   pwm_s  - synchronised PWM level (two flops after pwm_in)
//   rise   - high for one cycle when pwm_s goes 0 -> 1
module pwm_sync (
  input  logic clk,
  input  logic rstn,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic meta;
  logic pwm_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta  <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      meta  <= pwm_in;
      pwm_s <= meta;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers one WIDTH-bit sample per PWM period (PERIOD = 2**WIDTH
// clocks) by measuring high-time between consecutive rising edges.
//   clk        - clock, rising edge
//   rstn       - synchronous active-low reset
//   pwm_in     - asynchronous PWM stream
//   sample_o   - recovered sample (held until replaced)
//   valid_o    - sample_o holds an unconsumed sample
//   ready_i    - consumer takes the sample when valid_o & ready_i
//   locked     - LOCK_N consecutive periods of exactly PERIOD clocks seen
//   period_err - one-cycle pulse after a rise that ended a wrong-length period
//   overrun    - sticky: a sample was dropped because the buffer was full
//   state_dbg  - current FSM state
//
// Handshake: a sample transfers on any rising edge where valid_o & ready_i.
// valid_o never drops without a transfer; a new sample arriving while the
// held one is unconsumed is discarded and recorded in overrun.
module pwm_demod
  import synth_pkg::*;
#(
  parameter int WIDTH  = SYNTH_WIDTH,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             locked,
  output logic             period_err,
  output logic             overrun,
  output demod_state_t     state_dbg
);

  localparam int             PERIOD   = pwm_period(WIDTH);
  localparam logic [WIDTH:0] CNT_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] PER_FULL = (WIDTH+1)'(PERIOD);
  // One clock past a full period with no rise means the edge is missing.
  localparam logic [WIDTH:0] PER_TMO  = (WIDTH+1)'(PERIOD + 1);
  localparam logic [3:0]     LOCK_C   = 4'(LOCK_N);

  logic pwm_s;
  logic rise;

  pwm_sync u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise)
  );

  demod_state_t   state, state_nxt;
  logic [WIDTH:0] per_cnt;
  logic [WIDTH:0] hi_cnt;
  logic [3:0]     good_cnt;

  logic             emit;
  logic [WIDTH-1:0] emit_val;
  logic             err_nxt;
  logic             good_clr;
  logic             good_inc;
  logic             cnt_restart;  // per_cnt/hi_cnt <= 1
  logic             cnt_zero;     // per_cnt/hi_cnt <= 0

  always_comb begin
    state_nxt   = state;
    emit        = 1'b0;
    emit_val    = '0;
    err_nxt     = 1'b0;
    good_clr    = 1'b0;
    good_inc    = 1'b0;
    cnt_restart = 1'b0;
    cnt_zero    = 1'b0;
    case (state)
      ACQ: begin
        if (rise) begin
          // First period after acquisition is partial; measure from here.
          state_nxt   = RUN;
          cnt_restart = 1'b1;
        end else if (per_cnt == PER_FULL) begin
          // Constant level: report 0% or 100%. Reloading 0 makes the
          // free-running cadence PERIOD+1 edges.
          emit     = 1'b1;
          emit_val = {WIDTH{pwm_s}};
          cnt_zero = 1'b1;
        end
      end
      RUN: begin
        if (rise) begin
          cnt_restart = 1'b1;
          if (per_cnt == PER_FULL) begin
            emit     = 1'b1;
            emit_val = hi_cnt[WIDTH-1:0];
            good_inc = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            good_clr = 1'b1;
          end
        end else if (per_cnt == PER_TMO) begin
          emit        = 1'b1;
          emit_val    = {WIDTH{pwm_s}};
          good_clr    = 1'b1;
          cnt_restart = 1'b1;
          state_nxt   = ACQ;
        end
      end
      default: state_nxt = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ACQ;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      good_cnt   <= '0;
      sample_o   <= '0;
      valid_o    <= 1'b0;
      period_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_err <= err_nxt;

      if (cnt_restart) begin
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
      end else if (cnt_zero) begin
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        per_cnt <= per_cnt + CNT_ONE;
        hi_cnt  <= hi_cnt + {{WIDTH{1'b0}}, pwm_s};
      end

      if (good_clr) begin
        good_cnt <= '0;
      end else if (good_inc && (good_cnt != LOCK_C)) begin
        good_cnt <= good_cnt + 4'd1;
      end

      if (emit) begin
        if (!valid_o || ready_i) begin
          sample_o <= emit_val;
          valid_o  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign locked    = (good_cnt == LOCK_C);
  assign state_dbg = state;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: self-checking bench for pwm_demod with WIDTH=4, LOCK_N=2.
// Each scenario builds a pwm_in/ready_i waveform, plays it starting with one
// reset edge, and compares every post-edge output against an edge-timing
// model (rise times, period lengths, high-time sums), plus scenario checks.
`timescale 1ns/1ps
module tb_pwm_demod;
  import synth_pkg::*;

  localparam int W    = 4;
  localparam int P    = 16;
  localparam int LN   = 2;
  localparam int MAXN = 700;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         pwm_in = 1'b0;
  logic         ready_i = 1'b0;
  logic [W-1:0] sample_o;
  logic         valid_o;
  logic         locked;
  logic         period_err;
  logic         overrun;
  demod_state_t state_dbg;

  pwm_demod #(.WIDTH(W), .LOCK_N(LN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pwm_in     (pwm_in),
    .sample_o   (sample_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .locked     (locked),
    .period_err (period_err),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Waveform: index 0 is the reset edge, 1..wlen are running edges.
  bit wave[0:MAXN];
  bit rdy[0:MAXN];
  int wlen;

  // Packed outputs: {sample[8:5], valid[4], locked[3], err[2], ovr[1], run[0]}
  logic [8:0] act[0:MAXN];
  logic [8:0] exp_v[0:MAXN];

  // ---------------- waveform builders ----------------
  task automatic wave_clear();
    wlen = 0;
    for (int i = 0; i <= MAXN; i++) begin
      wave[i] = 1'b0;
      rdy[i]  = 1'b1;
    end
  endtask

  task automatic add_period(input int hi, input int len);
    for (int i = 0; i < len; i++) begin
      wlen++;
      wave[wlen] = (i < hi);
    end
  endtask

  task automatic add_level(input bit v, input int len);
    for (int i = 0; i < len; i++) begin
      wlen++;
      wave[wlen] = v;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_trace();
    for (int e = 0; e <= wlen; e++) begin
      rstn    = (e != 0);
      pwm_in  = wave[e];
      ready_i = rdy[e];
      @(posedge clk);
      #1;
      act[e] = {sample_o, valid_o, locked, period_err, overrun, state_dbg == RUN};
    end
    rstn = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Synchronised level seen by the decision made at edge e: pwm_in as driven
  // two edges earlier; anything from before reset reads as 0.
  function automatic bit ps(input int e);
    return (e >= 3) ? wave[e-2] : 1'b0;
  endfunction

  task automatic build_model();
    bit           in_run;
    int           t0, ld, r, good, val;
    bit           v, ovr, rise, emit, err;
    logic [W-1:0] s;
    in_run = 1'b0; t0 = 0; ld = 0; r = 0; good = 0;
    v = 1'b0; ovr = 1'b0; s = '0;
    exp_v[0] = '0;
    for (int e = 1; e <= wlen; e++) begin
      rise = ps(e) && !ps(e-1);
      emit = 1'b0;
      err  = 1'b0;
      val  = 0;
      if (!in_run) begin
        if (rise) begin
          in_run = 1'b1;
          r = e;
        end else if (e == t0 + P + 1 - ld) begin
          emit = 1'b1;
          val  = ps(e) ? P - 1 : 0;
          t0 = e;
          ld = 0;
        end
      end else if (rise) begin
        if (e - r == P) begin
          emit = 1'b1;
          for (int j = 0; j < P; j++) val += ps(r + j);
          if (good < LN) good++;
        end else begin
          err  = 1'b1;
          good = 0;
        end
        r = e;
      end else if (e - r == P + 1) begin
        emit = 1'b1;
        val  = ps(e) ? P - 1 : 0;
        good = 0;
        in_run = 1'b0;
        t0 = e;
        ld = 1;
      end
      if (emit) begin
        if (!v || rdy[e]) begin
          s = val[W-1:0];
          v = 1'b1;
        end else begin
          ovr = 1'b1;
        end
      end else if (rdy[e]) begin
        v = 1'b0;
      end
      exp_v[e] = {s, v, (good == LN), err, ovr, in_run};
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    wave_clear();
    add_level(1'b0, 4);
    build_model();
    run_trace();
    n_checks++;
    if (act[0] !== 9'b0) $display("FAIL reset_state: got %b want %b", act[0], 9'b0);
    else n_pass++;
    for (int e = 1; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL reset_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
    end
  endtask

  task automatic test_steady_duty();
    int cnt5, nerr, first_lock;
    wave_clear();
    for (int k = 0; k < 6; k++) add_period(5, P);
    build_model();
    run_trace();
    cnt5 = 0; nerr = 0; first_lock = -1;
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL steady_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
      if (act[e][4] && act[e][8:5] == 4'd5) cnt5++;
      if (act[e][2]) nerr++;
      if (act[e][3] && first_lock < 0) first_lock = e;
    end
    n_checks++;
    if (cnt5 !== 5) $display("FAIL steady_count: got %0d samples of 5 want 5", cnt5);
    else n_pass++;
    n_checks++;
    if (first_lock !== 35) $display("FAIL steady_lock_edge: got %0d want 35", first_lock);
    else n_pass++;
    n_checks++;
    if (nerr !== 0) $display("FAIL steady_no_err: got %0d pulses want 0", nerr);
    else n_pass++;
  endtask

  task automatic test_constant_levels();
    int cnt0, cnt15, nlock;
    wave_clear();
    add_level(1'b0, 40);
    add_level(1'b1, 40);
    build_model();
    run_trace();
    cnt0 = 0; cnt15 = 0; nlock = 0;
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL const_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
      if (act[e][4] && act[e][8:5] == 4'd0) cnt0++;
      if (act[e][4] && act[e][8:5] == 4'd15) cnt15++;
      if (act[e][3]) nlock++;
    end
    n_checks++;
    if (cnt0 !== 2 || cnt15 !== 2)
      $display("FAIL const_samples: got %0d zeros %0d fulls want 2 and 2", cnt0, cnt15);
    else n_pass++;
    n_checks++;
    if (nlock !== 0) $display("FAIL const_unlocked: got %0d locked cycles want 0", nlock);
    else n_pass++;
  endtask

  task automatic test_period_glitch();
    int nerr, n8_after;
    wave_clear();
    for (int k = 0; k < 4; k++) add_period(8, P);
    add_period(8, 12);
    for (int k = 0; k < 3; k++) add_period(8, P);
    build_model();
    run_trace();
    nerr = 0; n8_after = 0;
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL glitch_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
      if (act[e][2]) nerr++;
      if (e > 79 && act[e][4] && act[e][8:5] == 4'd8) n8_after++;
    end
    n_checks++;
    if (nerr !== 1) $display("FAIL glitch_err_count: got %0d want 1", nerr);
    else n_pass++;
    n_checks++;
    if (act[79][2] !== 1'b1 || act[79][3] !== 1'b0)
      $display("FAIL glitch_err_edge: got err %b locked %b want 1 0", act[79][2], act[79][3]);
    else n_pass++;
    n_checks++;
    if (n8_after !== 2 || act[wlen][3] !== 1'b1)
      $display("FAIL glitch_relock: got %0d samples locked %b want 2 1", n8_after, act[wlen][3]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    wave_clear();
    for (int k = 0; k < 6; k++) add_period(3, P);
    for (int e = 0; e <= 58; e++) rdy[e] = 1'b0;
    build_model();
    run_trace();
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL bp_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
    end
    n_checks++;
    if (act[50][8:5] !== 4'd3 || act[50][4] !== 1'b1)
      $display("FAIL bp_hold: got sample %0d valid %b want 3 1", act[50][8:5], act[50][4]);
    else n_pass++;
    n_checks++;
    if (act[34][1] !== 1'b0 || act[35][1] !== 1'b1)
      $display("FAIL bp_overrun_set: got %b%b want 01", act[34][1], act[35][1]);
    else n_pass++;
    n_checks++;
    if (act[wlen][1] !== 1'b1) $display("FAIL bp_overrun_sticky: got %b want 1", act[wlen][1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d[4];
    for (int k = 0; k < 4; k++) d[k] = $urandom_range(1, 14);
    wave_clear();
    for (int k = 0; k < 4; k++) add_period(d[k], P);
    for (int e = 0; e <= wlen; e++) rdy[e] = 1'b0;
    rdy[35] = 1'b1;
    rdy[51] = 1'b1;
    build_model();
    run_trace();
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL b2b_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
    end
    n_checks++;
    if (act[35][8:5] !== 4'(d[1]) || act[35][4] !== 1'b1 || act[35][1] !== 1'b0)
      $display("FAIL b2b_accept_emit: got sample %0d valid %b ovr %b want %0d 1 0",
               act[35][8:5], act[35][4], act[35][1], d[1]);
    else n_pass++;
    n_checks++;
    if (act[51][8:5] !== 4'(d[2]) || act[wlen][1] !== 1'b0)
      $display("FAIL b2b_second: got sample %0d ovr %b want %0d 0",
               act[51][8:5], act[wlen][1], d[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int first_v;
    // Locked on duty 5, then stop 7 cycles into a period.
    wave_clear();
    for (int k = 0; k < 4; k++) add_period(5, P);
    add_period(5, 7);
    build_model();
    run_trace();
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL rmid_pre_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
    end
    n_checks++;
    if (act[wlen][3] !== 1'b1) $display("FAIL rmid_locked_before: got %b want 1", act[wlen][3]);
    else n_pass++;
    // Reset lands on cycle 7; the stream continues with cycles 8..15.
    wave_clear();
    add_level(1'b0, 8);
    for (int k = 0; k < 4; k++) add_period(5, P);
    build_model();
    run_trace();
    first_v = -1;
    n_checks++;
    if (act[0] !== 9'b0) $display("FAIL rmid_reset_state: got %b want %b", act[0], 9'b0);
    else n_pass++;
    for (int e = 1; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL rmid_post_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
      if (act[e][4] && first_v < 0) first_v = e;
    end
    n_checks++;
    if (first_v !== 27) $display("FAIL rmid_first_sample: got edge %0d want 27", first_v);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind, len, hi;
    wave_clear();
    while (wlen < MAXN - 60) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        add_level(1'($urandom_range(0, 1)), $urandom_range(20, 40));
      end else if (kind <= 2) begin
        len = $urandom_range(10, 22);
        add_period($urandom_range(1, len - 1), len);
      end else begin
        hi = $urandom_range(1, P - 1);
        add_period(hi, P);
      end
    end
    for (int e = 0; e <= wlen; e++) rdy[e] = ($urandom_range(0, 3) != 0);
    build_model();
    run_trace();
    for (int e = 0; e <= wlen; e++) begin
      n_checks++;
      if (act[e] !== exp_v[e])
        $display("FAIL random_trace edge %0d: got %b want %b", e, act[e], exp_v[e]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_steady_duty();
    test_constant_levels();
    test_period_glitch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
